// File: rtl/mem_responder_if.sv
// mem_responder_if: msyn/ssyn bus between an initiator and the RAM responder.
// Carries the request fields and the registered completion/error response.
interface mem_responder_if;
  logic        msyn;
  logic [15:0] addr;
  logic        we;
  logic        bytew;
  logic [15:0] d_in;
  logic [15:0] d_out;
  logic        ssyn;
  logic        err;

  modport master (
    output msyn, addr, we, bytew, d_in,
    input  d_out, ssyn, err
  );

  modport slave (
    input  msyn, addr, we, bytew, d_in,
    output d_out, ssyn, err
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: 16-bit word RAM behind a msyn/ssyn handshake.
// Programmable wait states, byte lanes, bus error on bad address.
module mem_responder #(
  parameter int SIZE_WORDS  = 4096,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_responder_if.slave bus
);

  localparam int AW = (SIZE_WORDS > 1) ? $clog2(SIZE_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACK,
    ERR
  } state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [AW-1:0] widx;
  logic          hi;
  logic          we_q;
  logic          byte_q;
  logic [15:0]   data_q;
  logic [15:0]   d_out_q;
  logic          ssyn_q;
  logic          err_q;

  logic [15:0]   mem [SIZE_WORDS];

  logic          bad;
  logic          access;
  logic [15:0]   word;
  logic [15:0]   rdata;

  assign bad = (!bus.bytew && bus.addr[0]) ||
               ({17'd0, bus.addr[15:1]} >= 32'(SIZE_WORDS));

  assign access = (state == BUSY) && (cnt == 4'd0);

  assign word  = mem[widx];
  assign rdata = byte_q ? {8'h00, hi ? word[15:8] : word[7:0]}
                        : word;

  assign bus.d_out = d_out_q;
  assign bus.ssyn  = ssyn_q;
  assign bus.err   = err_q;

  // RAM write port; never reset so contents survive reset_n.
  always_ff @(posedge clk) begin
    if (access && we_q) begin
      if (!byte_q)
        mem[widx] <= data_q;
      else if (hi)
        mem[widx][15:8] <= data_q[7:0];
      else
        mem[widx][7:0] <= data_q[7:0];
    end
  end

  // Handshake FSM: latch request, count wait states, respond.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      widx    <= '0;
      hi      <= 1'b0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      data_q  <= 16'h0000;
      d_out_q <= 16'h0000;
      ssyn_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          ssyn_q <= 1'b0;
          err_q  <= 1'b0;
          if (bus.msyn) begin
            widx   <= bus.addr[AW:1];
            hi     <= bus.addr[0];
            we_q   <= bus.we;
            byte_q <= bus.bytew;
            data_q <= bus.d_in;
            if (bad) begin
              state <= ERR;
              err_q <= 1'b1;
            end else begin
              state <= BUSY;
              cnt   <= 4'(WAIT_CYCLES);
            end
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state  <= ACK;
            ssyn_q <= 1'b1;
            if (!we_q)
              d_out_q <= rdata;
          end
        end
        ACK: begin
          if (!bus.msyn) begin
            state  <= IDLE;
            ssyn_q <= 1'b0;
          end
        end
        ERR: begin
          if (!bus.msyn) begin
            state <= IDLE;
            err_q <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: three responders (WAIT 1, 0, 3) on one request stream.
// Table vectors, randomized traffic vs a byte-addressed model, corner cases.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        msyn = 1'b0;
  logic        we = 1'b0;
  logic        bytew = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [15:0] d_in = 16'h0000;

  logic [2:0]  ssyn_v;
  logic [2:0]  err_v;
  logic [15:0] dout_v [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic int wc(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_responder_if bus();
    assign bus.msyn  = msyn;
    assign bus.addr  = addr;
    assign bus.we    = we;
    assign bus.bytew = bytew;
    assign bus.d_in  = d_in;
    assign ssyn_v[g] = bus.ssyn;
    assign err_v[g]  = bus.err;
    assign dout_v[g] = bus.d_out;
    mem_responder #(
      .SIZE_WORDS (4096),
      .WAIT_CYCLES((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
    );
  end

  // Reference model: byte-addressed, little-endian storage.
  logic [7:0]  ref_b [bit [15:0]];
  logic [15:0] ref_dout = 16'h0000;

  function automatic void model_step(
    input  logic w, input logic bw,
    input  logic [15:0] a, input logic [15:0] d,
    output logic bad, output logic [15:0] dout);
    bad = (!bw && a[0]) || (32'(a) >= 32'(2 * 4096));
    if (!bad) begin
      if (w) begin
        ref_b[a] = d[7:0];
        if (!bw) ref_b[a + 16'd1] = d[15:8];
      end else if (bw) begin
        ref_dout = {8'h00, ref_b[a]};
      end else begin
        ref_dout = {ref_b[a + 16'd1], ref_b[a]};
      end
    end
    dout = ref_dout;
  endfunction

  task automatic chk(input string name, input int g,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h want %h", name, g, act, exp);
    end
  endtask

  task automatic txn(input logic w, input logic bw,
                     input logic [15:0] a, input logic [15:0] d,
                     input logic e_err, input logic [15:0] e_dout,
                     input int hold);
    int lat [3];
    int n;
    lat = '{0, 0, 0};
    n = 0;
    @(negedge clk);
    we = w; bytew = bw; addr = a; d_in = d; msyn = 1'b1;
    while (n < 40 && (lat[0] == 0 || lat[1] == 0 || lat[2] == 0)) begin
      @(posedge clk); #1;
      n++;
      for (int g = 0; g < 3; g++)
        if (lat[g] == 0 && (ssyn_v[g] || err_v[g])) lat[g] = n;
      chk("excl", 0, 32'(ssyn_v & err_v), 32'd0);
    end
    for (int g = 0; g < 3; g++) begin
      chk("latency", g, 32'(lat[g]), 32'(e_err ? 1 : wc(g) + 2));
      chk("err", g, 32'(err_v[g]), 32'(e_err));
      chk("ssyn", g, 32'(ssyn_v[g]), 32'(!e_err));
      chk("d_out", g, 32'(dout_v[g]), 32'(e_dout));
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      addr = a + 16'd2; d_in = ~d;
      @(posedge clk); #1;
      chk("hold_ssyn", 0, 32'(ssyn_v), 32'(e_err ? 3'b000 : 3'b111));
    end
    @(negedge clk);
    msyn = 1'b0;
    @(posedge clk); #1;
    chk("drop_ssyn", 0, 32'(ssyn_v), 32'd0);
    chk("drop_err", 0, 32'(err_v), 32'd0);
  endtask

  task automatic mtxn(input logic w, input logic bw,
                      input logic [15:0] a, input logic [15:0] d,
                      input int hold);
    logic bad;
    logic [15:0] dout;
    model_step(w, bw, a, d, bad, dout);
    txn(w, bw, a, d, bad, dout, hold);
  endtask

  typedef struct {
    logic        w;
    logic        bw;
    logic [15:0] a;
    logic [15:0] d;
    logic        e_err;
    logic [15:0] e_dout;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic        mbad;
    logic [15:0] mdout;
    int          cnt [3];
    int          first [3];

    tbl[0]  = '{1'b1, 1'b0, 16'h0100, 16'h1234, 1'b0, 16'h0000};
    tbl[1]  = '{1'b0, 1'b0, 16'h0100, 16'h0000, 1'b0, 16'h1234};
    tbl[2]  = '{1'b1, 1'b1, 16'h0101, 16'h77AB, 1'b0, 16'h1234};
    tbl[3]  = '{1'b0, 1'b0, 16'h0100, 16'h0000, 1'b0, 16'hAB34};
    tbl[4]  = '{1'b0, 1'b1, 16'h0101, 16'h0000, 1'b0, 16'h00AB};
    tbl[5]  = '{1'b0, 1'b1, 16'h0100, 16'h0000, 1'b0, 16'h0034};
    tbl[6]  = '{1'b0, 1'b0, 16'h0003, 16'h0000, 1'b1, 16'h0034};
    tbl[7]  = '{1'b0, 1'b0, 16'h2000, 16'h0000, 1'b1, 16'h0034};
    tbl[8]  = '{1'b1, 1'b0, 16'h0101, 16'hDEAD, 1'b1, 16'h0034};
    tbl[9]  = '{1'b0, 1'b0, 16'h0100, 16'h0000, 1'b0, 16'hAB34};
    tbl[10] = '{1'b1, 1'b0, 16'h1FFE, 16'hC3D2, 1'b0, 16'hAB34};
    tbl[11] = '{1'b1, 1'b1, 16'h1FFF, 16'h005A, 1'b0, 16'hAB34};
    tbl[12] = '{1'b0, 1'b0, 16'h1FFE, 16'h0000, 1'b0, 16'h5AD2};

    #1 reset_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("rst_ssyn", g, 32'(ssyn_v[g]), 32'd0);
      chk("rst_err", g, 32'(err_v[g]), 32'd0);
      chk("rst_dout", g, 32'(dout_v[g]), 32'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    foreach (tbl[i]) begin
      model_step(tbl[i].w, tbl[i].bw, tbl[i].a, tbl[i].d, mbad, mdout);
      txn(tbl[i].w, tbl[i].bw, tbl[i].a, tbl[i].d,
          tbl[i].e_err, tbl[i].e_dout, 0);
    end

    for (int i = 0; i < 64; i++)
      mtxn(1'b1, 1'b0, 16'(2 * i), 16'($urandom), 0);

    for (int i = 0; i < 80; i++) begin
      logic [15:0] a;
      if ($urandom_range(0, 9) == 0)
        a = 16'h2000 | 16'($urandom);
      else
        a = 16'($urandom_range(0, 127));
      mtxn(1'($urandom), 1'($urandom), a, 16'($urandom), 0);
    end

    mtxn(1'b1, 1'b0, 16'h0030, 16'h1357, 10);
    mtxn(1'b0, 1'b0, 16'h0030, 16'h0000, 0);
    mtxn(1'b0, 1'b0, 16'h0032, 16'h0000, 0);

    mtxn(1'b1, 1'b0, 16'h0010, 16'h5555, 0);
    mtxn(1'b0, 1'b0, 16'h0010, 16'h0000, 0);
    @(negedge clk);
    we = 1'b1; bytew = 1'b0; addr = 16'h0010; d_in = 16'hAAAA;
    msyn = 1'b1;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("abort_ssyn", g, 32'(ssyn_v[g]), 32'd0);
      chk("abort_err", g, 32'(err_v[g]), 32'd0);
      chk("abort_dout", g, 32'(dout_v[g]), 32'd0);
    end
    @(negedge clk) msyn = 1'b0;
    @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    ref_dout = 16'h0000;
    mtxn(1'b0, 1'b0, 16'h0010, 16'h0000, 0);

    @(negedge clk);
    we = 1'b1; bytew = 1'b0; addr = 16'h0020; d_in = 16'hBEEF;
    msyn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    msyn = 1'b0; addr = 16'h0040; d_in = 16'h0000;
    cnt = '{0, 0, 0};
    first = '{0, 0, 0};
    for (int n = 2; n < 10; n++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 3; g++) begin
        if (ssyn_v[g]) begin
          cnt[g]++;
          if (first[g] == 0) first[g] = n;
        end
      end
      chk("busy_drop_err", 0, 32'(err_v), 32'd0);
    end
    for (int g = 0; g < 3; g++) begin
      chk("pulse_len", g, 32'(cnt[g]), 32'd1);
      chk("pulse_at", g, 32'(first[g]), 32'(wc(g) + 2));
    end
    model_step(1'b1, 1'b0, 16'h0020, 16'hBEEF, mbad, mdout);
    mtxn(1'b0, 1'b0, 16'h0020, 16'h0000, 0);
    mtxn(1'b0, 1'b0, 16'h0040, 16'h0000, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter SIZE_WORDS, default 4096, number of 16-bit RAM words (byte addresses 0 .. 2*SIZE_WORDS-1).
REQ-002 Parameter WAIT_CYCLES, default 1, extra wait states inserted before each access (range 0..15).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 msyn  input  1  master sync; high = request valid, held until ssyn or err seen.
REQ-006 addr  input  16  byte address from initiator.
REQ-007 we  input  1  1 = write, 0 = read.
REQ-008 bytew  input  1  1 = byte access, 0 = word access.
REQ-009 d_in  input  16  write data; byte writes use d_in[7:0].
REQ-010 d_out  output  16  registered read data.
REQ-011 ssyn  output  1  slave sync; registered transfer-complete acknowledge.
REQ-012 err  output  1  registered bus-error response.

Function
REQ-013 The FSM SHALL have states IDLE, BUSY, ACK and ERR.
REQ-014 In IDLE, a rising edge with msyn=1 SHALL latch addr, we, bytew and d_in; later changes on those inputs SHALL be ignored until IDLE is re-entered.
REQ-015 Same edge: if (bytew=0 and addr[0]=1) or addr[15:1] >= SIZE_WORDS, the next state SHALL be ERR; otherwise BUSY with wait counter loaded with WAIT_CYCLES.
REQ-016 In BUSY, counter nonzero SHALL decrement; counter zero SHALL perform the access and go to ACK on the same edge.
REQ-017 ssyn SHALL be high exactly in ACK; it first appears after the (WAIT_CYCLES+2)th rising edge, counting the msyn-sampling edge as the first.
REQ-018 Word write: stores latched d_in at word addr[15:1].
REQ-019 Byte write: stores d_in[7:0] into the low byte if addr[0]=0, or the high byte if addr[0]=1; the other byte is unchanged.
REQ-020 Word read: d_out = stored word.
REQ-021 Byte read: d_out[7:0] = selected byte and d_out[15:8] = 0.
REQ-022 d_out SHALL update only when a read completes, and SHALL hold between reads; writes SHALL leave d_out unchanged.
REQ-023 ACK SHALL persist while msyn=1; with msyn=0 the next edge SHALL go to IDLE and drop ssyn.
REQ-024 ERR SHALL assert err, never ssyn, and perform no memory access; it SHALL persist while msyn=1 and go to IDLE on the first edge with msyn=0.
REQ-025 If msyn drops during BUSY, the access SHALL still complete and ACK SHALL still be entered for at least one cycle.
REQ-026 A new request SHALL be accepted only from IDLE, so msyn must be seen low between transactions.
REQ-027 ssyn and err SHALL never be high together.

Reset
REQ-028 reset_n=0 SHALL immediately force the state to IDLE, ssyn=0, err=0, d_out=0 and wait counter=0, independent of clk.
REQ-029 Reset during BUSY SHALL abort the transaction; any write not yet performed SHALL NOT occur.
REQ-030 RAM contents SHALL NOT be cleared by reset.
REQ-031 After reset_n rises, the first rising edge with msyn=1 SHALL be accepted normally.

Verification
REQ-032 WAIT_CYCLES=1: word write 0x1234 to addr 0x0100, then word read of 0x0100 -> d_out=0x1234; ssyn rises after 3rd edge of each transaction.
REQ-033 Byte write 0xAB to 0x0101 over word 0x1234 -> word read of 0x0100 gives 0xAB34; byte read of 0x0101 gives d_out=0x00AB.
REQ-034 Word read at odd addr 0x0003, then a read at 0x2000 with SIZE_WORDS=4096 -> err=1 and ssyn=0 each time, memory unchanged, err drops one edge after msyn falls.
REQ-035 Write 0x5555 to 0x0010, then assert reset_n=0 while in BUSY -> ssyn/err/d_out=0 immediately; later read of 0x0010 returns its prior value.
REQ-036 Hold msyn high for 10 cycles after ssyn -> ssyn stays high, no second access; drop msyn -> ssyn=0 next edge; back-to-back request accepted one edge later.
REQ-037 WAIT_CYCLES=0 and WAIT_CYCLES=3 -> ssyn latency of exactly 2 and 5 edges; msyn dropped in BUSY -> write still committed and ssyn pulses one cycle.
